nes_oam_dma: RTL and testbench

- Sprite (OAM) DMA controller and bus owner for the CPU-side memory bus (16-bit address, 8-bit data, async-read/sync-write RAM with active-low write enable).
- A CPU write to $4014 halts the CPU and copies 256 bytes from page {data,8'h00} to the PPU OAM data port ($2004) as read/write pairs.
- Sits between the CPU core and the shared bus. Passes CPU traffic through when idle and drives the bus itself when busy.

---
 rtl/nes_dma_pkg.sv | 18 +
 rtl/nes_oam_dma.sv | 107 ++++++++++
 tb/tb_nes_oam_dma.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_dma_pkg.sv
// Shared types and constants for the OAM sprite DMA controller.
package nes_dma_pkg;

  // Controller state; HALT/ALIGN are dummy-read cycles before the copy loop.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int unsigned XFER_LEN      = 256;
  localparam logic [7:0]  LAST_INDEX    = 8'(XFER_LEN - 1);

endpackage

// File: rtl/nes_oam_dma.sv
// OAM sprite DMA: owns the CPU-side bus while copying one 256-byte page to $2004.
module nes_oam_dma
  import nes_dma_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_data,
  input  logic        i_cpu_w_n,
  output logic        o_cpu_rdy,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_data,
  output logic        o_bus_w_n,
  input  logic [7:0]  i_bus_q,
  output logic        o_dma_busy
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_index;
  logic [7:0] r_page;
  logic [7:0] r_latch;
  logic       r_parity;
  logic       w_trigger;

  // A CPU write to the DMA register only counts while the bus is passed through.
  assign w_trigger = (r_state == IDLE) && !i_cpu_w_n && (i_cpu_addr == DMA_REG_ADDR);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; the copy loop is aligned so every READ lands on an even cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_next = HALT;
      HALT:    w_next = r_parity ? READ : ALIGN;
      ALIGN:   w_next = READ;
      READ:    w_next = WRITE;
      WRITE:   w_next = (r_index == LAST_INDEX) ? IDLE : READ;
      default: w_next = IDLE;
    endcase
  end

  // Parity, page, index counter and read latch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_index  <= 8'h00;
      r_latch  <= 8'h00;
    end else begin
      r_parity <= ~r_parity;
      if (w_trigger) begin
        r_page  <= i_cpu_data;
        r_index <= 8'h00;
      end
      if (r_state == READ) begin
        r_latch <= i_bus_q;
      end
      if (r_state == WRITE) begin
        r_index <= r_index + 8'd1;
      end
    end
  end

  // Bus ownership mux: CPU passthrough when idle, DMA-generated cycles otherwise.
  always_comb begin
    o_bus_addr = i_cpu_addr;
    o_bus_data = i_cpu_data;
    o_bus_w_n  = i_cpu_w_n;
    o_cpu_rdy  = 1'b1;
    o_dma_busy = 1'b0;
    case (r_state)
      HALT, ALIGN: begin
        o_bus_addr = {r_page, 8'h00};
        o_bus_data = 8'h00;
        o_bus_w_n  = 1'b1;
        o_cpu_rdy  = 1'b0;
        o_dma_busy = 1'b1;
      end
      READ: begin
        o_bus_addr = {r_page, r_index};
        o_bus_data = 8'h00;
        o_bus_w_n  = 1'b1;
        o_cpu_rdy  = 1'b0;
        o_dma_busy = 1'b1;
      end
      WRITE: begin
        o_bus_addr = OAM_DATA_ADDR;
        o_bus_data = r_latch;
        o_bus_w_n  = 1'b0;
        o_cpu_rdy  = 1'b0;
        o_dma_busy = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Self-checking bench for nes_oam_dma: RAM model, OAM write sink, directed vectors.
module tb_nes_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        cpu_w_n  = 1'b1;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_w_n;
  logic [7:0]  bus_q;
  logic        dma_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  wr_data [0:4095];
  logic [15:0] wr_raddr [0:4095];
  logic        wr_par [0:4095];
  int          nwr = 0;
  int          cyc = 0;
  logic [15:0] prev_addr = 16'h0000;

  nes_oam_dma dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cpu_addr (cpu_addr),
    .i_cpu_data (cpu_data),
    .i_cpu_w_n  (cpu_w_n),
    .o_cpu_rdy  (cpu_rdy),
    .o_bus_addr (bus_addr),
    .o_bus_data (bus_data),
    .o_bus_w_n  (bus_w_n),
    .i_bus_q    (bus_q),
    .o_dma_busy (dma_busy)
  );

  always #5 clk = ~clk;

  // Asynchronous-read RAM.
  assign bus_q = mem[bus_addr];

  // Cycle parity, previous-cycle address and OAM write sink.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
    prev_addr <= bus_addr;
    if (dma_busy === 1'b1 && bus_w_n === 1'b0 && bus_addr == 16'h2004) begin
      wr_data[nwr]  <= bus_data;
      wr_raddr[nwr] <= prev_addr;
      wr_par[nwr]   <= cyc[0];
      nwr           <= nwr + 1;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w_n;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ew_n;
    logic        erdy;
    logic        ebusy;
  } vec_t;

  vec_t vt [7];

  function automatic logic [7:0] exp_byte(input logic [7:0] page, input int i);
    case (page)
      8'h02:   return 8'(i);
      8'hFF:   return ~8'(i);
      8'h03:   return 8'(i) ^ 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cpu_addr = 16'h8123;
    cpu_data = 8'hA5;
    cpu_w_n  = 1'b1;
  endtask

  // Advance until the current cycle has the requested parity.
  task automatic wait_par(input bit p);
    for (int k = 0; k < 4 && cyc[0] != p; k++) step();
  endtask

  // Drive the trigger in the current cycle, then step into HALT and check it.
  task automatic start_trigger(input logic [7:0] page, output bit hp);
    cpu_addr = 16'h4014;
    cpu_data = page;
    cpu_w_n  = 1'b0;
    #1;
    chk("trig_pass_addr", 32'(bus_addr), 32'h4014);
    chk("trig_pass_data", 32'(bus_data), 32'(page));
    chk("trig_pass_w_n", 32'(bus_w_n), 32'h0);
    chk("trig_rdy", 32'(cpu_rdy), 32'h1);
    step();
    idle_in();
    #1;
    chk("halt_busy", 32'(dma_busy), 32'h1);
    chk("halt_rdy", 32'(cpu_rdy), 32'h0);
    chk("halt_addr", 32'(bus_addr), 32'({page, 8'h00}));
    chk("halt_w_n", 32'(bus_w_n), 32'h1);
    chk("halt_data", 32'(bus_data), 32'h0);
    hp = cyc[0];
  endtask

  // Count busy cycles (HALT already counted); optionally inject a $4014 write.
  task automatic finish_xfer(input int exp_cnt, input int inject);
    int cnt = 1;
    int rdy_bad = 0;
    bit done = 0;
    for (int k = 0; k < 700 && !done; k++) begin
      step();
      if (cnt == inject) begin
        cpu_addr = 16'h4014;
        cpu_data = 8'h05;
        cpu_w_n  = 1'b0;
      end else begin
        idle_in();
      end
      #1;
      if (dma_busy) begin
        cnt++;
        if (cpu_rdy !== 1'b0) rdy_bad++;
      end else begin
        done = 1;
      end
    end
    chk("xfer_done", 32'(done), 32'h1);
    chk("busy_cycles", 32'(cnt), 32'(exp_cnt));
    chk("rdy_low_while_busy", 32'(rdy_bad), 32'h0);
    chk("rdy_after", 32'(cpu_rdy), 32'h1);
    chk("pass_after_addr", 32'(bus_addr), 32'h8123);
    chk("pass_after_data", 32'(bus_data), 32'hA5);
    chk("pass_after_w_n", 32'(bus_w_n), 32'h1);
  endtask

  task automatic check_writes(input int base, input logic [7:0] page);
    chk("write_count", 32'(nwr - base), 32'd256);
    for (int i = 0; i < 256; i++) begin
      chk("oam_data", 32'(wr_data[base + i]), 32'(exp_byte(page, i)));
      chk("read_addr", 32'(wr_raddr[base + i]), 32'({page, 8'(i)}));
      chk("write_parity", 32'(wr_par[base + i]), 32'h1);
    end
  endtask

  initial begin
    bit hp;
    int base;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = exp_byte(8'h02, i);
      mem[16'h0300 + i] = exp_byte(8'h03, i);
      mem[16'hFF00 + i] = exp_byte(8'hFF, i);
    end

    vt[0] = '{16'h1234, 8'h11, 1'b1, 16'h1234, 8'h11, 1'b1, 1'b1, 1'b0};
    vt[1] = '{16'h4015, 8'h0F, 1'b0, 16'h4015, 8'h0F, 1'b0, 1'b1, 1'b0};
    vt[2] = '{16'h2004, 8'h77, 1'b0, 16'h2004, 8'h77, 1'b0, 1'b1, 1'b0};
    vt[3] = '{16'h4014, 8'h09, 1'b1, 16'h4014, 8'h09, 1'b1, 1'b1, 1'b0};
    vt[4] = '{16'h4013, 8'h02, 1'b0, 16'h4013, 8'h02, 1'b0, 1'b1, 1'b0};
    vt[5] = '{16'hFFFF, 8'hFF, 1'b1, 16'hFFFF, 8'hFF, 1'b1, 1'b1, 1'b0};
    vt[6] = '{16'h0000, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0};

    // Reset.
    rst = 1'b1;
    idle_in();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(cpu_rdy), 32'h1);
    chk("rst_busy", 32'(dma_busy), 32'h0);
    chk("rst_pass_addr", 32'(bus_addr), 32'h8123);
    chk("rst_pass_w_n", 32'(bus_w_n), 32'h1);

    // Idle passthrough vectors; none of them may start a transfer.
    foreach (vt[i]) begin
      step();
      cpu_addr = vt[i].a;
      cpu_data = vt[i].d;
      cpu_w_n  = vt[i].w_n;
      #1;
      chk("vec_addr", 32'(bus_addr), 32'(vt[i].ea));
      chk("vec_data", 32'(bus_data), 32'(vt[i].ed));
      chk("vec_w_n", 32'(bus_w_n), 32'(vt[i].ew_n));
      chk("vec_rdy", 32'(cpu_rdy), 32'(vt[i].erdy));
      chk("vec_busy", 32'(dma_busy), 32'(vt[i].ebusy));
    end
    step();
    idle_in();
    #1;
    chk("vec_no_trigger", 32'(dma_busy), 32'h0);

    // Odd trigger cycle: HALT even, ALIGN inserted.
    wait_par(1'b1);
    base = nwr;
    start_trigger(8'h02, hp);
    finish_xfer(514, -1);
    check_writes(base, 8'h02);

    // Even trigger cycle: HALT odd, no ALIGN.
    step();
    wait_par(1'b0);
    base = nwr;
    start_trigger(8'h02, hp);
    finish_xfer(513, -1);
    check_writes(base, 8'h02);

    // Top page.
    step();
    base = nwr;
    start_trigger(8'hFF, hp);
    finish_xfer(hp ? 513 : 514, -1);
    check_writes(base, 8'hFF);

    // Reset after the 100th OAM write, then a fresh page-3 transfer.
    step();
    base = nwr;
    start_trigger(8'h02, hp);
    for (int k = 0; k < 700 && (nwr - base) < 100; k++) step();
    chk("reached_write_100", 32'(nwr - base), 32'd100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_rdy", 32'(cpu_rdy), 32'h1);
    chk("midrst_busy", 32'(dma_busy), 32'h0);
    chk("midrst_addr", 32'(bus_addr), 32'h8123);
    chk("midrst_data", 32'(bus_data), 32'hA5);
    chk("midrst_w_n", 32'(bus_w_n), 32'h1);
    step();
    chk("midrst_writes_kept", 32'(nwr - base), 32'd100);
    base = nwr;
    start_trigger(8'h03, hp);
    finish_xfer(hp ? 513 : 514, -1);
    check_writes(base, 8'h03);

    // $4014 write while busy must not retrigger or change the page.
    step();
    base = nwr;
    start_trigger(8'h02, hp);
    finish_xfer(hp ? 513 : 514, 200);
    check_writes(base, 8'h02);
    step();
    #1;
    chk("no_retrigger_busy", 32'(dma_busy), 32'h0);

    // Back-to-back: second trigger on the first idle cycle.
    base = nwr;
    start_trigger(8'h02, hp);
    finish_xfer(hp ? 513 : 514, -1);
    check_writes(base, 8'h02);
    base = nwr;
    start_trigger(8'h03, hp);
    finish_xfer(hp ? 513 : 514, -1);
    check_writes(base, 8'h03);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
